// File: rtl/sb_pkg.sv
// Shared constants for the forwarding scoreboard: slot indices, index/count widths, depth limits.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: SLOT_EX/SLOT_MEM/SLOT_WB slot positions, SB_IDX_W (winning-slot index width),
// SB_CNT_W (in-flight count width), legal DEPTH range and its check function.
// Entry record layout used by the top, MSB to LSB: {valid, is_load, rd[RADDR_W], data[DATA_W]}.
package sb_pkg;

  // Slot positions relative to ID: slot0 is the instruction currently in EX.
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  // Legal number of tracked slots.
  localparam int SB_DEPTH_MIN = 2;
  localparam int SB_DEPTH_MAX = 8;

  // Wide enough to index SB_DEPTH_MAX slots and to count all of them.
  localparam int SB_IDX_W = 3;
  localparam int SB_CNT_W = 4;

  function automatic bit sb_depth_legal(input int depth);
    return (depth >= SB_DEPTH_MIN) && (depth <= SB_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Priority matcher for one register read port over all in-flight scoreboard slots.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller turns a load winner in slot0 into a stall.
// Ports: i_used/i_addr = read port, i_valid/i_is_load/i_rd = per-slot state (bit k = slot k),
//        o_hit = some slot matches, o_idx = youngest matching slot, o_is_load = that slot is a load.
// Optional: SB_ZERO_REG_EN makes address 0 never match.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int RADDR_W = 3
) (
  input  logic                            i_used,
  input  logic [RADDR_W-1:0]              i_addr,
  input  logic [DEPTH-1:0]                i_valid,
  input  logic [DEPTH-1:0]                i_is_load,
  input  logic [DEPTH-1:0][RADDR_W-1:0]   i_rd,
  output logic                            o_hit,
  output logic [SB_IDX_W-1:0]             o_idx,
  output logic                            o_is_load
);

  logic w_addr_ok;

`ifdef SB_ZERO_REG_EN
  // r0 is hardwired zero: never bypassed, never a hazard.
  assign w_addr_ok = i_used && (i_addr != '0);
`else
  assign w_addr_ok = i_used;
`endif

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_hit     = 1'b0;
    o_idx     = '0;
    o_is_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_addr_ok && i_valid[k] && (i_rd[k] == i_addr)) begin
        o_hit     = 1'b1;
        o_idx     = SB_IDX_W'(k);
        o_is_load = i_is_load[k];
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Destination-register scoreboard with EX/load/retired bypass to both ID read ports.
// Latency: forwarding and stall are combinational from slot state and same-cycle inputs.
// Backpressure: stall_o for exactly one cycle on a load-use dependency; flush turns ID into a bubble.
// Ports: clk_i/rst_i (sync, active-high); id_* = ID instruction; flush_i kills it;
//        ex_result_i = slot0 ALU result, mem_rdata_i = slot1 load data;
//        fwd_rs{1,2}_{hit,data}_o = bypass; stall_o; inflight_o = valid slot count.
// Optional: define SB_ZERO_REG_EN to treat r0 as hardwired zero (never tracked or matched).
module fwd_scoreboard
  import sb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int DEPTH   = SLOT_WB + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [RADDR_W-1:0]  id_rs1_i,
  input  logic [RADDR_W-1:0]  id_rs2_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic [RADDR_W-1:0]  id_rd_i,
  input  logic                id_we_i,
  input  logic                id_load_i,
  input  logic                flush_i,
  input  logic [DATA_W-1:0]   ex_result_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                fwd_rs1_hit_o,
  output logic [DATA_W-1:0]   fwd_rs1_data_o,
  output logic                fwd_rs2_hit_o,
  output logic [DATA_W-1:0]   fwd_rs2_data_o,
  output logic                stall_o,
  output logic [3:0]          inflight_o
);

  localparam bit DEPTH_OK = sb_depth_legal(DEPTH);

  generate
    if (!DEPTH_OK) begin : g_bad_depth
      $error("fwd_scoreboard: DEPTH must be within 2..8");
    end
  endgenerate

  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t r_slot [DEPTH];

  logic [DEPTH-1:0]              w_valid;
  logic [DEPTH-1:0]              w_is_load;
  logic [DEPTH-1:0][RADDR_W-1:0] w_rd;
  logic [DATA_W-1:0]             w_src [DEPTH];

  logic                w_rs1_hit, w_rs2_hit;
  logic [SB_IDX_W-1:0] w_rs1_idx, w_rs2_idx;
  logic                w_rs1_load, w_rs2_load;
  logic                w_stall;
  logic                w_id_we;
  logic [SB_CNT_W-1:0] w_cnt;

  // Per-slot forwarding source. A result still being produced this cycle
  // (ALU in slot0, load in slot1) comes from the live input, otherwise from storage.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_valid[k]   = r_slot[k].valid;
      w_is_load[k] = r_slot[k].is_load;
      w_rd[k]      = r_slot[k].rd;
      w_src[k]     = r_slot[k].data;
      if ((k == SLOT_EX) && !r_slot[k].is_load) begin
        w_src[k] = ex_result_i;
      end
      if ((k == SLOT_MEM) && r_slot[k].is_load) begin
        w_src[k] = mem_rdata_i;
      end
    end
  end

  sb_match #(.DEPTH(DEPTH), .RADDR_W(RADDR_W)) u_match_rs1 (
    .i_used    (id_rs1_used_i),
    .i_addr    (id_rs1_i),
    .i_valid   (w_valid),
    .i_is_load (w_is_load),
    .i_rd      (w_rd),
    .o_hit     (w_rs1_hit),
    .o_idx     (w_rs1_idx),
    .o_is_load (w_rs1_load)
  );

  sb_match #(.DEPTH(DEPTH), .RADDR_W(RADDR_W)) u_match_rs2 (
    .i_used    (id_rs2_used_i),
    .i_addr    (id_rs2_i),
    .i_valid   (w_valid),
    .i_is_load (w_is_load),
    .i_rd      (w_rd),
    .o_hit     (w_rs2_hit),
    .o_idx     (w_rs2_idx),
    .o_is_load (w_rs2_load)
  );

  always_comb begin
    fwd_rs1_data_o = '0;
    fwd_rs2_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_rs1_hit && (w_rs1_idx == SB_IDX_W'(k))) begin
        fwd_rs1_data_o = w_src[k];
      end
      if (w_rs2_hit && (w_rs2_idx == SB_IDX_W'(k))) begin
        fwd_rs2_data_o = w_src[k];
      end
    end
  end

  assign fwd_rs1_hit_o = w_rs1_hit;
  assign fwd_rs2_hit_o = w_rs2_hit;

  // Only a load still in EX is unforwardable; one cycle later it sits in MEM
  // and bypasses mem_rdata_i, so the stall self-clears after one cycle.
  assign w_stall = (w_rs1_hit && w_rs1_load && (w_rs1_idx == SB_IDX_W'(SLOT_EX))) ||
                   (w_rs2_hit && w_rs2_load && (w_rs2_idx == SB_IDX_W'(SLOT_EX)));
  assign stall_o = w_stall;

`ifdef SB_ZERO_REG_EN
  assign w_id_we = id_we_i && (id_rd_i != '0);
`else
  assign w_id_we = id_we_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k].valid <= 1'b0;
      end
    end else begin
      // Stalled or flushed ID instruction enters as a bubble.
      r_slot[0].valid   <= w_id_we && !w_stall && !flush_i;
      r_slot[0].is_load <= id_load_i;
      r_slot[0].rd      <= id_rd_i;
      r_slot[0].data    <= '0;
      // Capturing the source value on shift latches live EX/load results as they pass.
      for (int k = 1; k < DEPTH; k++) begin
        r_slot[k].valid   <= r_slot[k-1].valid;
        r_slot[k].is_load <= r_slot[k-1].is_load;
        r_slot[k].rd      <= r_slot[k-1].rd;
        r_slot[k].data    <= w_src[k-1];
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_cnt = w_cnt + SB_CNT_W'(r_slot[k].valid);
    end
  end

  assign inflight_o = w_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard (default parameters, DEPTH=3).
// Inputs change on the falling edge; outputs are sampled 2 time units later.
// Expected values are pushed to a scoreboard queue as each step is driven.
module tb_fwd_scoreboard;

  localparam int DEPTH = 3;

  logic        clk_i;
  logic        rst_i;
  logic [2:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i, id_we_i, id_load_i, flush_i;
  logic [15:0] ex_result_i, mem_rdata_i;
  logic        fwd_rs1_hit_o, fwd_rs2_hit_o, stall_o;
  logic [15:0] fwd_rs1_data_o, fwd_rs2_data_o;
  logic [3:0]  inflight_o;

  fwd_scoreboard #(.DATA_W(16), .RADDR_W(3), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .id_rd_i        (id_rd_i),
    .id_we_i        (id_we_i),
    .id_load_i      (id_load_i),
    .flush_i        (flush_i),
    .ex_result_i    (ex_result_i),
    .mem_rdata_i    (mem_rdata_i),
    .fwd_rs1_hit_o  (fwd_rs1_hit_o),
    .fwd_rs1_data_o (fwd_rs1_data_o),
    .fwd_rs2_hit_o  (fwd_rs2_hit_o),
    .fwd_rs2_data_o (fwd_rs2_data_o),
    .stall_o        (stall_o),
    .inflight_o     (inflight_o)
  );

  typedef struct packed {
    logic        h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
    logic        st;
    logic [3:0]  inf;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic [2:0]  rs1;
    logic        u1;
    logic [2:0]  rs2;
    logic        u2;
    logic [2:0]  rd;
    logic        we;
    logic        ld;
    logic        fl;
    logic [15:0] ex;
    logic [15:0] mem;
    obs_t        e;
    obs_t        m;
  } step_t;

  // Check masks: all fields, or all but one port's data (don't-care while stalling).
  localparam obs_t MA  = {1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'hF};
  localparam obs_t MD1 = {1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 4'hF};
  localparam obs_t MD2 = {1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 4'hF};

  obs_t exp_q[$];
  obs_t msk_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  obs_t got, e, m;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic obs_t E(input bit h1, input logic [15:0] d1, input bit h2,
                             input logic [15:0] d2, input bit st, input logic [3:0] inf);
    return {h1, d1, h2, d2, st, inf};
  endfunction

  function automatic step_t S(input bit rst, input logic [2:0] rs1, input bit u1,
                              input logic [2:0] rs2, input bit u2, input logic [2:0] rd,
                              input bit we, input bit ld, input bit fl,
                              input logic [15:0] ex, input logic [15:0] mem,
                              input obs_t ee, input obs_t mm);
    return {rst, rs1, u1, rs2, u2, rd, we, ld, fl, ex, mem, ee, mm};
  endfunction

  function automatic obs_t observe();
    return {fwd_rs1_hit_o, fwd_rs1_data_o, fwd_rs2_hit_o, fwd_rs2_data_o, stall_o, inflight_o};
  endfunction

  task automatic apply(input step_t s);
    rst_i         = s.rst;
    id_rs1_i      = s.rs1;
    id_rs1_used_i = s.u1;
    id_rs2_i      = s.rs2;
    id_rs2_used_i = s.u2;
    id_rd_i       = s.rd;
    id_we_i       = s.we;
    id_load_i     = s.ld;
    flush_i       = s.fl;
    ex_result_i   = s.ex;
    mem_rdata_i   = s.mem;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      apply(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, '0, '0));
    end
  endtask

  task automatic test_reset();
    step_t st[$];
    // Reset held two cycles while ID tries to issue: nothing may be tracked.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      apply(S(1, 3, 1, 3, 1, 3, 1, 0, 0, 16'h1111, 16'h2222, '0, '0));
    end
    st.push_back(S(0, 3, 1, 3, 1, 0, 0, 0, 0, 16'h1111, 16'h2222, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL reset[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
  endtask

  task automatic test_ex_fwd();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 3, 1, 0, 0, 16'h0000, 16'h0000, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 3, 1, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, E(1, 16'h1234, 0, 0, 0, 1), MA));
    st.push_back(S(0, 3, 1, 3, 1, 0, 0, 0, 0, 16'h9999, 16'h5555, E(1, 16'h1234, 1, 16'h1234, 0, 1), MA));
    st.push_back(S(0, 3, 1, 3, 1, 0, 0, 0, 0, 16'h8888, 16'h6666, E(1, 16'h1234, 1, 16'h1234, 0, 1), MA));
    st.push_back(S(0, 3, 1, 3, 1, 0, 0, 0, 0, 16'h7777, 16'h4444, E(0, 0, 0, 0, 0, 0), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL ex_fwd[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  task automatic test_load_use();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 2, 1, 1, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 0, 0, 2, 1, 6, 1, 0, 0, 16'h0, 16'h0, E(0, 0, 1, 0, 1, 1), MD2));
    st.push_back(S(0, 0, 0, 2, 1, 6, 1, 0, 0, 16'h0, 16'hBEEF, E(0, 0, 1, 16'hBEEF, 0, 1), MA));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 2), MA));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 1), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL load_use[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  task automatic test_youngest();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 4, 1, 0, 0, 16'h0000, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0002, 16'h0, E(0, 0, 0, 0, 0, 1), MA));
    st.push_back(S(0, 0, 0, 0, 0, 4, 1, 0, 0, 16'h0000, 16'h0, E(0, 0, 0, 0, 0, 1), MA));
    st.push_back(S(0, 4, 1, 4, 1, 0, 0, 0, 0, 16'h0001, 16'h0, E(1, 16'h0001, 1, 16'h0001, 0, 2), MA));
    st.push_back(S(0, 4, 1, 4, 1, 0, 0, 0, 0, 16'h7777, 16'h0, E(1, 16'h0001, 1, 16'h0001, 0, 1), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL youngest[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  task automatic test_flush();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 5, 1, 0, 1, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 5, 1, 5, 1, 0, 0, 0, 0, 16'h5555, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    // Flush coinciding with a load-use hazard: stall stays asserted.
    st.push_back(S(0, 0, 0, 0, 0, 1, 1, 1, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 1, 1, 0, 0, 7, 1, 0, 1, 16'h0, 16'h0, E(1, 0, 0, 0, 1, 1), MD1));
    st.push_back(S(0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'hCAFE, E(1, 16'hCAFE, 0, 0, 0, 1), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL flush[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  task automatic test_zero_reg();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
`ifdef SB_ZERO_REG_EN
    st.push_back(S(0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h00AB, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
`else
    st.push_back(S(0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h00AB, 16'h0, E(1, 16'h00AB, 1, 16'h00AB, 0, 1), MA));
    st.push_back(S(0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 1), MA));
    st.push_back(S(0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, E(1, 0, 0, 0, 1, 2), MD1));
`endif
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL zero_reg[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  task automatic test_mid_reset();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 2, 1, 0, 0, 16'h0000, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 0, 0, 0, 0, 3, 1, 0, 0, 16'h0B0B, 16'h0, E(0, 0, 0, 0, 0, 1), MA));
    st.push_back(S(1, 2, 1, 3, 1, 4, 1, 0, 0, 16'h0C0C, 16'h0, E(1, 16'h0B0B, 1, 16'h0C0C, 0, 2), MA));
    st.push_back(S(0, 2, 1, 3, 1, 0, 0, 0, 0, 16'h0D0D, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL mid_reset[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  task automatic test_used_flags();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 3, 1, 1, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 3, 0, 3, 0, 0, 0, 0, 0, 16'h0, 16'h0, E(0, 0, 0, 0, 0, 1), MA));
    st.push_back(S(0, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h3333, E(1, 16'h3333, 0, 0, 0, 1), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL used_flags[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    st.push_back(S(0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 16'h0, E(0, 0, 0, 0, 0, 0), MA));
    st.push_back(S(0, 1, 1, 0, 0, 1, 1, 0, 0, 16'h0011, 16'h0, E(1, 16'h0011, 0, 0, 0, 1), MA));
    st.push_back(S(0, 1, 1, 1, 1, 0, 0, 0, 0, 16'h0022, 16'h0, E(1, 16'h0022, 1, 16'h0022, 0, 2), MA));
    st.push_back(S(0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0033, 16'h0, E(1, 16'h0022, 0, 0, 0, 2), MA));
    foreach (st[i]) begin
      @(negedge clk_i);
      apply(st[i]);
      exp_q.push_back(st[i].e);
      msk_q.push_back(st[i].m);
      #2;
      got = observe(); e = exp_q.pop_front(); m = msk_q.pop_front();
      n_total++;
      if ((got & m) !== (e & m))
        $display("FAIL back_to_back[%0d] got=%h want=%h mask=%h", i, got, e, m);
      else n_pass++;
    end
    drain(DEPTH);
  endtask

  initial begin
    apply(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, '0, '0));
    test_reset();
    test_ex_fwd();
    test_load_use();
    test_youngest();
    test_flush();
    test_zero_reg();
    test_mid_reset();
    test_used_flags();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
